// File: rtl/mc_ctrl_pkg.sv
// Shared state and ALU encodings, opcode/funct map and legality check for mc_ctrl.
// Build option: MC_CTRL_BNE_EN adds bne (Op 000101) to the supported set.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXE_R  = 4'd6,
      S_EXE_I  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      ALU_NOP  = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_SUB  = 3'b010,
      ALU_AND  = 3'b011,
      ALU_OR   = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_SLTU = 3'b110
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      alu_op_t    alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic funct_supported(input logic [5:0] funct);
      logic ok;
      case (funct)
         FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU: ok = 1'b1;
         default:                                          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic op_supported(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      case (op)
         OP_RTYPE: ok = funct_supported(funct);
         OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_CTRL_BNE_EN
         OP_BNE:   ok = 1'b1;
`endif
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation and immediate-extension decode for the execute states of mc_ctrl.
module mc_aludec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output alu_op_t    alu_op,
   output logic       ext_op
);

   always_comb begin
      alu_op = ALU_NOP;
      ext_op = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: alu_op = ALU_ADD;
               FN_SUBU: alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLTU: alu_op = ALU_SLTU;
               default: alu_op = ALU_NOP;
            endcase
         end
         OP_ADDI: begin
            alu_op = ALU_ADD;
            ext_op = 1'b1;
         end
         OP_SLTI: begin
            alu_op = ALU_SLT;
            ext_op = 1'b1;
         end
         // Logical immediates take the zero-extended operand.
         OP_ANDI: alu_op = ALU_AND;
         OP_ORI:  alu_op = ALU_OR;
         default: begin
            alu_op = ALU_NOP;
            ext_op = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main controller: one state register, outputs decoded from state/Op/Funct/Zero.
// Build option: MC_CTRL_BNE_EN enables bne through the BRANCH state with inverted Zero qualification.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       EXTOp,
   output logic [2:0] ALUOp,
   output logic       InstrDone,
   output logic       Illegal
);

   state_t  state;
   state_t  next_state;
   ctrl_t   ctl;
   alu_op_t dec_alu;
   logic    dec_ext;
   logic    legal;

   mc_aludec u_aludec (
      .op     (Op),
      .funct  (Funct),
      .alu_op (dec_alu),
      .ext_op (dec_ext)
   );

   assign legal = op_supported(Op, Funct);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            if (!legal) begin
               next_state = S_FETCH;
            end else begin
               case (Op)
                  OP_LW, OP_SW:                       next_state = S_MEMADR;
                  OP_RTYPE:                           next_state = S_EXE_R;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  next_state = S_EXE_I;
                  OP_BEQ, OP_BNE:                     next_state = S_BRANCH;
                  OP_J:                               next_state = S_JUMP;
                  default:                            next_state = S_FETCH;
               endcase
            end
         end
         S_MEMADR: next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = S_MEMWB;
         S_EXE_R,
         S_EXE_I:  next_state = S_ALUWB;
         default:  next_state = S_FETCH;
      endcase
   end

   always_comb begin
      ctl        = '0;
      ctl.alu_op = ALU_NOP;
      case (state)
         S_FETCH: begin
            ctl.ir_write  = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.alu_op    = ALU_ADD;
            ctl.pc_write  = 1'b1;
         end
         S_DECODE: begin
            ctl.alu_src_b = 2'b11;
            ctl.ext_op    = 1'b1;
            ctl.alu_op    = ALU_ADD;
            ctl.illegal   = ~legal;
         end
         S_MEMADR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.ext_op    = 1'b1;
            ctl.alu_op    = ALU_ADD;
         end
         S_MEMRD: ctl.i_or_d = 1'b1;
         S_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctl.i_or_d     = 1'b1;
            ctl.mem_write  = 1'b1;
            ctl.instr_done = 1'b1;
         end
         S_EXE_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = dec_alu;
         end
         S_EXE_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.ext_op    = dec_ext;
            ctl.alu_op    = dec_alu;
         end
         S_ALUWB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = (Op == OP_RTYPE);
            ctl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_op     = ALU_SUB;
            ctl.pc_source  = 2'b01;
            ctl.instr_done = 1'b1;
`ifdef MC_CTRL_BNE_EN
            ctl.pc_write   = (Op == OP_BNE) ? ~Zero : Zero;
`else
            ctl.pc_write   = Zero;
`endif
         end
         S_JUMP: begin
            ctl.pc_source  = 2'b10;
            ctl.pc_write   = 1'b1;
            ctl.instr_done = 1'b1;
         end
         default: ;
      endcase
      // State is already FETCH during reset; only the side-effecting strobes need masking.
      if (!rstn) begin
         ctl.pc_write   = 1'b0;
         ctl.mem_write  = 1'b0;
         ctl.ir_write   = 1'b0;
         ctl.reg_write  = 1'b0;
         ctl.instr_done = 1'b0;
         ctl.illegal    = 1'b0;
      end
   end

   assign PCWrite   = ctl.pc_write;
   assign PCSource  = ctl.pc_source;
   assign IorD      = ctl.i_or_d;
   assign MemWrite  = ctl.mem_write;
   assign IRWrite   = ctl.ir_write;
   assign RegWrite  = ctl.reg_write;
   assign RegDst    = ctl.reg_dst;
   assign MemtoReg  = ctl.mem_to_reg;
   assign ALUSrcA   = ctl.alu_src_a;
   assign ALUSrcB   = ctl.alu_src_b;
   assign EXTOp     = ctl.ext_op;
   assign ALUOp     = ctl.alu_op;
   assign InstrDone = ctl.instr_done;
   assign Illegal   = ctl.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expected control sequences are queued, a monitor checks every cycle.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic [5:0] Op, Funct;
   logic       Zero;
   logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, EXTOp, InstrDone, Illegal;
   logic [1:0] PCSource, ALUSrcB;
   logic [2:0] ALUOp;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp),
      .InstrDone(InstrDone), .Illegal(Illegal)
   );

   typedef struct packed {
      logic       pcw;
      logic [1:0] pcs;
      logic       iord, memw, irw, regw, regdst, m2r, srca;
      logic [1:0] srcb;
      logic       ext;
      logic [2:0] alu;
      logic       done, ill;
   } ctl_t;

   ctl_t act;
   assign act = {PCWrite, PCSource, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, EXTOp, ALUOp, InstrDone, Illegal};

   localparam logic [2:0] A_ADD = 3'b001, A_SUB = 3'b010, A_AND = 3'b011,
                          A_OR  = 3'b100, A_SLT = 3'b101, A_SLTU = 3'b110;
   localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_I = 4, K_BEQ = 5, K_BNE = 6, K_J = 7;
`ifdef MC_CTRL_BNE_EN
   localparam bit BNE_ON = 1'b1;
`else
   localparam bit BNE_ON = 1'b0;
`endif

   localparam logic [5:0] OPS [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
                                       6'b001101, 6'b001010, 6'b000100, 6'b000101, 6'b000010};
   localparam logic [5:0] FNS [6]  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b101011};

   ctl_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    passes = 0;

   function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return (fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b101011}) ? K_R : K_ILL;
         6'b001000, 6'b001100, 6'b001101, 6'b001010: return K_I;
         6'b000100: return K_BEQ;
         6'b000101: return BNE_ON ? K_BNE : K_ILL;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000) begin
         case (fn)
            6'b100001: return A_ADD;
            6'b100011: return A_SUB;
            6'b100100: return A_AND;
            6'b100101: return A_OR;
            6'b101010: return A_SLT;
            default:   return A_SLTU;
         endcase
      end
      case (op)
         6'b001000: return A_ADD;
         6'b001010: return A_SLT;
         6'b001100: return A_AND;
         default:   return A_OR;
      endcase
   endfunction

   // Expected cycle-by-cycle outputs for one instruction; only the first lim cycles are queued.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lim, output int n);
      ctl_t seq[$];
      ctl_t v;
      int   k;
      Op = op; Funct = fn; Zero = z;
      k = kind_of(op, fn);
      v = '0; v.pcw = 1; v.irw = 1; v.srcb = 2'b01; v.alu = A_ADD;
      seq.push_back(v);
      v = '0; v.srcb = 2'b11; v.ext = 1; v.alu = A_ADD; v.ill = (k == K_ILL);
      seq.push_back(v);
      if (k == K_LW || k == K_SW) begin
         v = '0; v.srca = 1; v.srcb = 2'b10; v.ext = 1; v.alu = A_ADD;
         seq.push_back(v);
      end
      case (k)
         K_LW: begin
            v = '0; v.iord = 1; seq.push_back(v);
            v = '0; v.regw = 1; v.m2r = 1; v.done = 1; seq.push_back(v);
         end
         K_SW: begin
            v = '0; v.iord = 1; v.memw = 1; v.done = 1; seq.push_back(v);
         end
         K_R, K_I: begin
            v = '0; v.srca = 1; v.alu = alu_of(op, fn);
            if (k == K_I) begin
               v.srcb = 2'b10;
               v.ext  = (op == 6'b001000 || op == 6'b001010);
            end
            seq.push_back(v);
            v = '0; v.regw = 1; v.regdst = (k == K_R); v.done = 1; seq.push_back(v);
         end
         K_BEQ, K_BNE: begin
            v = '0; v.srca = 1; v.alu = A_SUB; v.pcs = 2'b01; v.done = 1;
            v.pcw = (k == K_BEQ) ? z : ~z;
            seq.push_back(v);
         end
         K_J: begin
            v = '0; v.pcs = 2'b10; v.pcw = 1; v.done = 1; seq.push_back(v);
         end
         default: ;
      endcase
      n = (lim < seq.size()) ? lim : seq.size();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(seq[i]);
         tag_q.push_back($sformatf("op=%b fn=%b z=%b cyc%0d", op, fn, z, i + 1));
      end
   endtask

   task automatic push_reset(input int n);
      ctl_t v;
      v = '0; v.srcb = 2'b01; v.alu = A_ADD;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(v);
         tag_q.push_back($sformatf("reset cyc%0d", i + 1));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
      int n;
      issue(op, fn, z, 99, n);
      step(n);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act === e) passes++;
            else $display("FAIL ctl %s: actual %h required %h", t, act, e);
         end
      end
   end

   initial begin
      int         n;
      logic [5:0] op, fn;
      rstn = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
      step(1);
      push_reset(2);
      step(2);
      rstn = 1'b1;

      run(6'b000000, 6'b101011, 1'b0);
      run(6'b100011, 6'b000000, 1'b0);
      run(6'b101011, 6'b000000, 1'b1);
      run(6'b000100, 6'b000000, 1'b1);
      run(6'b000100, 6'b000000, 1'b0);
      run(6'b001101, 6'b000000, 1'b0);
      run(6'b111111, 6'b000000, 1'b0);
      run(6'b000101, 6'b000000, 1'b0);
      run(6'b000101, 6'b000000, 1'b1);
      run(6'b001000, 6'b000000, 1'b0);
      run(6'b000010, 6'b000000, 1'b0);
      run(6'b000000, 6'b000000, 1'b0);

      // Reset held three cycles in the middle of a lw.
      issue(6'b100011, 6'b000000, 1'b0, 2, n);
      step(2);
      rstn = 1'b0;
      push_reset(3);
      step(3);
      rstn = 1'b1;
      run(6'b101011, 6'b000000, 1'b0);

      for (int i = 0; i < 150; i++) begin
         int idx;
         idx = $urandom_range(0, 11);
         op  = (idx < 10) ? OPS[idx] : 6'($urandom_range(0, 63));
         fn  = ($urandom_range(0, 3) != 0) ? FNS[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
         run(op, fn, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
